alu_rr_arbiter: RTL

- Shares one combinational 16-bit ALU (ALU_struct_2 interface: A, B, carry-in, 3-bit opcode -> W, zero, neg) between two requesters.
- Round-robin grant; operands registered before drive; ALU result and flags captured into a response register.
- Sits between two command sources (e.g. sequencer ports) and the single ALU instance.

---
 rtl/alu_rr_arbiter_pkg.sv | 36 +++
 rtl/alu_rr_arbiter_rr_pick2.sv | 17 +
 rtl/alu_rr_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/alu_rr_arbiter_pkg.sv
// alu_arb_pkg: shared types and constants for the two-requester ALU arbiter.
//   state_t   : arbiter FSM states
//   alu_cmd_t : one latched ALU command (operands, carry-in, opcode)
//   alu_rsp_t : one captured ALU response (result, flags, illegal-op error)
package alu_arb_pkg;

  localparam int W      = 16;  // operand / result width
  localparam int OPW    = 3;   // opcode width
  localparam int OP_MAX = 6;   // highest legal opcode

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ERR   = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           cin;
    logic [OPW-1:0] op;
  } alu_cmd_t;

  typedef struct packed {
    logic [W-1:0] w;
    logic         zero;
    logic         neg;
    logic         err;
  } alu_rsp_t;

  function automatic logic op_legal(input logic [OPW-1:0] op);
    return (op <= OPW'(OP_MAX));
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker.
//   valid_i : request valid per requester
//   ptr_i   : requester that has priority this round
//   grant_o : chosen requester (meaningful only when any_o is high)
//   any_o   : at least one requester is valid
module rr_pick2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic       grant_o,
  output logic       any_o
);

  assign any_o   = |valid_i;
  // Priority holder wins if it is asking; otherwise the other one gets it.
  assign grant_o = valid_i[ptr_i] ? ptr_i : ~ptr_i;

endmodule

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one combinational ALU between two requesters with
// round-robin grant, registered ALU drive and a registered response.
//
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   req_valid/req_ready : per-requester command handshake
//   req_a/req_b/req_cin/req_op : packed per-requester command fields
//   rsp_valid/rsp_ready : per-requester response handshake
//   rsp_w/rsp_zero/rsp_neg/rsp_err : shared response bus
//   alu_a/alu_b/alu_cin/alu_op : registered drive into the ALU
//   alu_w/alu_zero/alu_neg     : ALU result and flags
//   busy                : FSM not in IDLE
//   ops_done            : completed-transaction counter (wraps)
//   dbg_state           : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is a one-cycle strobe raised only in IDLE for the
// granted requester; the command must be present in that cycle. rsp_valid
// is raised for the granted requester in RESP and the response bus is held
// until rsp_ready of that same requester; rsp_ready of the other is ignored.
module alu_rr_arbiter
  import alu_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2*W-1:0]   req_a,
  input  logic [2*W-1:0]   req_b,
  input  logic [1:0]       req_cin,
  input  logic [2*OPW-1:0] req_op,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [W-1:0]     rsp_w,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic             rsp_err,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic             alu_cin,
  output logic [OPW-1:0]   alu_op,
  input  logic [W-1:0]     alu_w,
  input  logic             alu_zero,
  input  logic             alu_neg,
  output logic             busy,
  output logic [15:0]      ops_done,
  output state_t           dbg_state
);

  state_t   state_q, state_d;
  logic     ptr_q, ptr_d;
  logic     gnt_q, gnt_d;
  alu_cmd_t cmd_q, cmd_d;
  alu_rsp_t rsp_q, rsp_d;
  logic [15:0] ops_done_q, ops_done_d;

  logic       pick_g;
  logic       pick_any;
  alu_cmd_t   sel_cmd;
  logic [1:0] ready_c;
  logic [1:0] valid_c;

  rr_pick2 u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_g),
    .any_o   (pick_any)
  );

  always_comb begin
    sel_cmd.a   = pick_g ? req_a[2*W-1:W]     : req_a[W-1:0];
    sel_cmd.b   = pick_g ? req_b[2*W-1:W]     : req_b[W-1:0];
    sel_cmd.cin = pick_g ? req_cin[1]         : req_cin[0];
    sel_cmd.op  = pick_g ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    cmd_d      = cmd_q;
    rsp_d      = rsp_q;
    ops_done_d = ops_done_q;
    ready_c    = 2'b00;
    valid_c    = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          ready_c[pick_g] = 1'b1;
          cmd_d           = sel_cmd;
          gnt_d           = pick_g;
          state_d         = op_legal(sel_cmd.op) ? ISSUE : ERR;
        end
      end
      ISSUE: begin
        rsp_d.w    = alu_w;
        rsp_d.zero = alu_zero;
        rsp_d.neg  = alu_neg;
        rsp_d.err  = 1'b0;
        state_d    = RESP;
      end
      ERR: begin
        // Drive registers are left alone so the ALU inputs do not toggle.
        rsp_d.w    = '0;
        rsp_d.zero = 1'b0;
        rsp_d.neg  = 1'b0;
        rsp_d.err  = 1'b1;
        state_d    = RESP;
      end
      RESP: begin
        valid_c[gnt_q] = 1'b1;
        if (rsp_ready[gnt_q]) begin
          ptr_d      = ~gnt_q;
          ops_done_d = ops_done_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      gnt_q      <= 1'b0;
      cmd_q      <= '0;
      rsp_q      <= '0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      cmd_q      <= cmd_d;
      rsp_q      <= rsp_d;
      ops_done_q <= ops_done_d;
    end
  end

  // Strobes are masked during reset so nothing is accepted or delivered
  // while a transaction is being aborted.
  assign req_ready = rst ? 2'b00 : ready_c;
  assign rsp_valid = rst ? 2'b00 : valid_c;

  assign rsp_w     = rsp_q.w;
  assign rsp_zero  = rsp_q.zero;
  assign rsp_neg   = rsp_q.neg;
  assign rsp_err   = rsp_q.err;
  assign alu_a     = cmd_q.a;
  assign alu_b     = cmd_q.b;
  assign alu_cin   = cmd_q.cin;
  assign alu_op    = cmd_q.op;
  assign busy      = (state_q != IDLE);
  assign ops_done  = ops_done_q;
  assign dbg_state = state_q;

endmodule
